tftlcd_timing_gen: RTL

- Generates raster timing for the 480x272 TFT LCD: Hsync, Vsync, DE, and the running HsyncCount/VsyncCount consumed by the pixel/RGB generators.
- Producer end of the HsyncCount/VsyncCount/DE interface; sits between the clock source and every pixel-drawing block in the tftlcd IP.
- Also supplies active-area pixel coordinates, line/frame strobes and a frame counter used for cursor/animation pacing.

---
 rtl/tftlcd_pkg.sv | 42 ++++
 rtl/tftlcd_pixel_tick.sv | 45 ++++
 rtl/tftlcd_timing_gen.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/tftlcd_pkg.sv
// -----------------------------------------------------------------------------
// tftlcd_pkg
// Shared timing constants for the 480x272 TFT panel and the state encoding of
// the raster generator. Pixel/RGB consumers import this package so that they
// agree with the generator on where the active window lies.
//
// Contents:
//   H_SYNC..V_FP        default porch/sync/active sizes (pixel ticks / lines)
//   H_TOTAL, V_TOTAL    full line length and full frame height
//   H_START, V_START    first active column / row
//   ST_IDLE, ST_RUN     generator FSM encoding
//   in_span()           window test shared by generator and consumers
// -----------------------------------------------------------------------------
package tftlcd_pkg;

    localparam int H_SYNC  = 41;
    localparam int H_BP    = 2;
    localparam int H_ACT   = 480;
    localparam int H_FP    = 2;
    localparam int V_SYNC  = 10;
    localparam int V_BP    = 2;
    localparam int V_ACT   = 272;
    localparam int V_FP    = 2;

    localparam int H_TOTAL = H_SYNC + H_BP + H_ACT + H_FP;
    localparam int H_START = H_SYNC + H_BP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACT + V_FP;
    localparam int V_START = V_SYNC + V_BP;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // True when start <= pos < start+len. Written as an offset compare so the
    // window end never has to be formed, which could overflow 10 bits when the
    // window touches the end of a 1024-long line.
    function automatic logic in_span(input logic [9:0] pos,
                                     input logic [9:0] start,
                                     input logic [9:0] len);
        return (pos >= start) && ((pos - start) < len);
    endfunction

endpackage

// File: rtl/tftlcd_pixel_tick.sv
// -----------------------------------------------------------------------------
// tftlcd_pixel_tick
// Clock-enable divider: asserts tick_o once every CLK_DIV clk cycles. While
// restart_i is high the count is forced back to 0 and no tick is issued, so
// the first tick after restart drops lands exactly CLK_DIV cycles later.
//
// Ports:
//   clk        system clock, rising edge
//   rstn       asynchronous active-low reset
//   restart_i  synchronous restart, holds the divider at 0
//   tick_o     one-cycle pixel tick (combinational from the divider state)
// -----------------------------------------------------------------------------
module tftlcd_pixel_tick #(
    parameter int CLK_DIV = 1
) (
    input  logic clk,
    input  logic rstn,
    input  logic restart_i,
    output logic tick_o
);

    localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);

    logic [3:0] div_q;
    logic [3:0] div_d;

    always_comb begin
        if (restart_i || (div_q == DIV_LAST)) begin
            div_d = '0;
        end else begin
            div_d = div_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    assign tick_o = !restart_i && (div_q == DIV_LAST);

endmodule

// File: rtl/tftlcd_timing_gen.sv
// -----------------------------------------------------------------------------
// tftlcd_timing_gen
// Raster timing generator for the TFT panel. Produces the running horizontal
// and vertical counts plus sync, data-enable, active-area coordinates, line
// and frame strobes and a completed-frame counter. Every output is a flop;
// the decodes are computed from the next counts so they never skew against
// the counts they describe.
//
// Ports:
//   clk         system clock, rising edge
//   rstn        asynchronous active-low reset
//   en          run request; low blanks the panel and parks the counters
//   Hsync       horizontal sync, active low
//   Vsync       vertical sync, active low
//   DE          data enable, high inside the active window
//   HsyncCount  horizontal position 0..H_TOTAL-1
//   VsyncCount  vertical position 0..V_TOTAL-1
//   PixelX      active-area column while DE, else 0
//   PixelY      active-area row while DE, else 0
//   LineStart   one-clk pulse on the first clk of HsyncCount==0
//   FrameStart  one-clk pulse on the first clk of (0,0)
//   FrameCnt    completed frames, wraps at 2^16
// -----------------------------------------------------------------------------
module tftlcd_timing_gen #(
    parameter int H_SYNC  = tftlcd_pkg::H_SYNC,
    parameter int H_BP    = tftlcd_pkg::H_BP,
    parameter int H_ACT   = tftlcd_pkg::H_ACT,
    parameter int H_FP    = tftlcd_pkg::H_FP,
    parameter int V_SYNC  = tftlcd_pkg::V_SYNC,
    parameter int V_BP    = tftlcd_pkg::V_BP,
    parameter int V_ACT   = tftlcd_pkg::V_ACT,
    parameter int V_FP    = tftlcd_pkg::V_FP,
    parameter int CLK_DIV = 1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        en,
    output logic        Hsync,
    output logic        Vsync,
    output logic        DE,
    output logic [9:0]  HsyncCount,
    output logic [9:0]  VsyncCount,
    output logic [8:0]  PixelX,
    output logic [8:0]  PixelY,
    output logic        LineStart,
    output logic        FrameStart,
    output logic [15:0] FrameCnt
);

    import tftlcd_pkg::*;

    localparam int H_TOT = H_SYNC + H_BP + H_ACT + H_FP;
    localparam int H_STA = H_SYNC + H_BP;
    localparam int V_TOT = V_SYNC + V_BP + V_ACT + V_FP;
    localparam int V_STA = V_SYNC + V_BP;

    if ((H_TOT > 1024) || (V_TOT > 1024) || (H_ACT > 512) || (V_ACT > 512) ||
        (CLK_DIV < 1) || (CLK_DIV > 16)) begin : g_bad_params
        $error("tftlcd_timing_gen: timing does not fit 10-bit counts / 9-bit coordinates");
    end

    localparam logic [9:0] H_LAST    = 10'(H_TOT - 1);
    localparam logic [9:0] V_LAST    = 10'(V_TOT - 1);
    localparam logic [9:0] H_SYNC_C  = 10'(H_SYNC);
    localparam logic [9:0] V_SYNC_C  = 10'(V_SYNC);
    localparam logic [9:0] H_START_C = 10'(H_STA);
    localparam logic [9:0] V_START_C = 10'(V_STA);
    localparam logic [9:0] H_ACT_C   = 10'(H_ACT);
    localparam logic [9:0] V_ACT_C   = 10'(V_ACT);

    logic [0:0]  state_q, state_d;
    logic [9:0]  h_q, h_d, v_q, v_d;
    logic [8:0]  px_q, px_d, py_q, py_d;
    logic        hs_q, hs_d, vs_q, vs_d, de_q, de_d;
    logic        ls_q, ls_d, fs_q, fs_d;
    logic [15:0] fc_q, fc_d;
    logic        run_d;
    logic        tick;
    logic        div_restart;

    // The divider only runs while we stay in RUN; entry and exit edges both
    // park it at 0 so each count is held a full CLK_DIV cycles after entry.
    assign div_restart = !((state_q == ST_RUN) && en);

    tftlcd_pixel_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_pixel_tick (
        .clk       (clk),
        .rstn      (rstn),
        .restart_i (div_restart),
        .tick_o    (tick)
    );

    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        v_d     = v_q;
        fc_d    = fc_q;
        ls_d    = 1'b0;
        fs_d    = 1'b0;

        if (state_q == ST_IDLE) begin
            if (en) begin
                state_d = ST_RUN;
                h_d     = '0;
                v_d     = '0;
                ls_d    = 1'b1;
                fs_d    = 1'b1;
            end
        end else if (!en) begin
            // Abandon the frame immediately; FrameCnt keeps its value.
            state_d = ST_IDLE;
            h_d     = '0;
            v_d     = '0;
        end else if (tick) begin
            if (h_q == H_LAST) begin
                h_d  = '0;
                ls_d = 1'b1;
                if (v_q == V_LAST) begin
                    v_d  = '0;
                    fs_d = 1'b1;
                    fc_d = fc_q + 16'd1;
                end else begin
                    v_d = v_q + 10'd1;
                end
            end else begin
                h_d = h_q + 10'd1;
            end
        end

        // Decodes follow the next counts so they register in the same edge.
        run_d = (state_d == ST_RUN);
        hs_d  = !(run_d && (h_d < H_SYNC_C));
        vs_d  = !(run_d && (v_d < V_SYNC_C));
        de_d  = run_d && in_span(h_d, H_START_C, H_ACT_C) && in_span(v_d, V_START_C, V_ACT_C);
        px_d  = de_d ? 9'(h_d - H_START_C) : '0;
        py_d  = de_d ? 9'(v_d - V_START_C) : '0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            h_q     <= '0;
            v_q     <= '0;
            px_q    <= '0;
            py_q    <= '0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            de_q    <= 1'b0;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
            fc_q    <= '0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            v_q     <= v_d;
            px_q    <= px_d;
            py_q    <= py_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            de_q    <= de_d;
            ls_q    <= ls_d;
            fs_q    <= fs_d;
            fc_q    <= fc_d;
        end
    end

    assign Hsync      = hs_q;
    assign Vsync      = vs_q;
    assign DE         = de_q;
    assign HsyncCount = h_q;
    assign VsyncCount = v_q;
    assign PixelX     = px_q;
    assign PixelY     = py_q;
    assign LineStart  = ls_q;
    assign FrameStart = fs_q;
    assign FrameCnt   = fc_q;

endmodule
